imm_gen_pipe: RTL and testbench

//   Pipelined, parametrised RISC-V immediate generator for the decode stage.

---
 rtl/imm_gen_pipe.sv | 135 +++++++++++++
 tb/tb_imm_gen_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator with a 2-entry skid buffer on a valid/ready interface.
// Define IMM_ERR_CHECK_EN to add the imm_err port flagging reserved/illegal immediate formats.
`timescale 1ns/1ps
module imm_gen_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      Instr,
    input  logic [2:0]       ImmSrc,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmExt,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ERR_CHECK_EN
    ,
    output logic             imm_err
`endif
);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    state_t state;
    entry_t head, second, incoming;
    logic   push, pop;
    logic   unused_opcode;

    assign unused_opcode = ^Instr[6:0];

    always_comb begin
        incoming     = '0;
        incoming.tag = in_tag;
        case (ImmSrc)
            3'b000: begin
                incoming.imm        = {XLEN{Instr[31]}};
                incoming.imm[11:0]  = Instr[31:20];
            end
            3'b001: begin
                incoming.imm        = {XLEN{Instr[31]}};
                incoming.imm[11:0]  = {Instr[31:25], Instr[11:7]};
            end
            3'b010: begin
                incoming.imm        = {XLEN{Instr[31]}};
                incoming.imm[11:0]  = {Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            end
            3'b011: begin
                incoming.imm        = {XLEN{Instr[31]}};
                incoming.imm[19:0]  = {Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            end
            3'b100: begin
                incoming.imm        = {XLEN{Instr[31]}};
                incoming.imm[31:0]  = {Instr[31:12], 12'b0};
            end
            3'b101: incoming.imm[4:0] = Instr[19:15];
            3'b110: begin
                if (XLEN == 64)
                    incoming.imm[5:0] = Instr[25:20];
                else
                    incoming.imm[4:0] = Instr[24:20];
            end
            default: incoming.imm = '0;
        endcase
        incoming.err = (ImmSrc == 3'b111) ||
                       ((ImmSrc == 3'b110) && (XLEN == 32) && Instr[25]);
    end

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // head is the output register; second only fills while head is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            head      <= '0;
            second    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head      <= incoming;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head <= incoming;
                    end else if (push) begin
                        second   <= incoming;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head     <= second;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ImmExt  = head.imm;
    assign out_tag = head.tag;

`ifdef IMM_ERR_CHECK_EN
    assign imm_err = head.err;
`else
    logic unused_err;
    assign unused_err = head.err ^ second.err;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: a 32-bit instance (formats, backpressure, reset) and a 64-bit instance.
`timescale 1ns/1ps
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [7:0]  tag;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_instr, a_imm;
    logic [2:0]  a_src;
    logic [7:0]  a_in_tag, a_out_tag;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_instr;
    logic [63:0] b_imm;
    logic [2:0]  b_src;
    logic [7:0]  b_in_tag, b_out_tag;

`ifdef IMM_ERR_CHECK_EN
    logic a_err, b_err;
`endif

    exp_t qa[$];
    exp_t qb[$];
    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) u32 (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .Instr(a_instr), .ImmSrc(a_src), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .ImmExt(a_imm), .out_tag(a_out_tag)
`ifdef IMM_ERR_CHECK_EN
        , .imm_err(a_err)
`endif
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) u64 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .Instr(b_instr), .ImmSrc(b_src), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .ImmExt(b_imm), .out_tag(b_out_tag)
`ifdef IMM_ERR_CHECK_EN
        , .imm_err(b_err)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected: got tag %0h expected no output", a_out_tag);
            end else begin
                e = qa.pop_front();
                check("a_imm", 64'(a_imm), e.imm);
                check("a_tag", 64'(a_out_tag), 64'(e.tag));
`ifdef IMM_ERR_CHECK_EN
                check("a_err", 64'(a_err), 64'(e.err));
`endif
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected: got tag %0h expected no output", b_out_tag);
            end else begin
                e = qb.pop_front();
                check("b_imm", b_imm, e.imm);
                check("b_tag", 64'(b_out_tag), 64'(e.tag));
`ifdef IMM_ERR_CHECK_EN
                check("b_err", 64'(b_err), 64'(e.err));
`endif
            end
        end
    end

    task automatic send_a(input logic [31:0] instr, input logic [2:0] src, input logic [7:0] tag,
                          input logic [63:0] imm, input logic err);
        exp_t e;
        int unsigned n = 0;
        e.imm = imm; e.tag = tag; e.err = err;
        a_in_valid = 1'b1; a_instr = instr; a_src = src; a_in_tag = tag;
        forever begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_a_timeout: got in_ready=0 expected acceptance of tag %0h", tag);
                break;
            end
        end
        @(posedge clk);
        #1;
        a_in_valid = 1'b0;
    endtask

    task automatic send_b(input logic [31:0] instr, input logic [2:0] src, input logic [7:0] tag,
                          input logic [63:0] imm, input logic err);
        exp_t e;
        int unsigned n = 0;
        e.imm = imm; e.tag = tag; e.err = err;
        b_in_valid = 1'b1; b_instr = instr; b_src = src; b_in_tag = tag;
        forever begin
            @(negedge clk);
            if (b_in_ready) begin
                qb.push_back(e);
                break;
            end
            n++;
            if (n > 50) begin
                checks++;
                failures++;
                $display("FAIL send_b_timeout: got in_ready=0 expected acceptance of tag %0h", tag);
                break;
            end
        end
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((qa.size() != 0 || qb.size() != 0) && n < 40) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 64'(qa.size() + qb.size()), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_instr = '0; a_src = '0; a_in_tag = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_instr = '0; b_src = '0; b_in_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_imm", 64'(a_imm), 64'd0);
        check("rst_tag", 64'(a_out_tag), 64'd0);
        check("rst_imm64", b_imm, 64'd0);
        @(posedge clk);
        #1;

        // 1-cycle latency from accept, then a full-rate stream of formats
        send_a(32'hFFF00093, 3'b000, 8'h10, 64'hFFFFFFFF, 1'b0);
        check("latency_valid", 64'(a_out_valid), 64'd1);
        send_a(32'hFE000EE3, 3'b010, 8'h11, 64'hFFFFFFFC, 1'b0);
        send_a(32'h000FD073, 3'b101, 8'h12, 64'h0000001F, 1'b0);
        send_a(32'h00812623, 3'b001, 8'h13, 64'h0000000C, 1'b0);
        send_a(32'hFF9FF06F, 3'b011, 8'h14, 64'hFFFFFFF8, 1'b0);
        send_a(32'h12345037, 3'b100, 8'h15, 64'h12345000, 1'b0);
        send_a(32'h800000B7, 3'b100, 8'h16, 64'h80000000, 1'b0);
        send_a(32'h01F0D093, 3'b110, 8'h17, 64'h0000001F, 1'b0);
        send_a(32'h0200D093, 3'b110, 8'h18, 64'h00000000, 1'b1);
        send_a(32'hFFFFFFFF, 3'b111, 8'h19, 64'h00000000, 1'b1);
        send_a(32'h7FF00093, 3'b000, 8'h1A, 64'h000007FF, 1'b0);

        send_b(32'h800000B7, 3'b100, 8'h30, 64'hFFFFFFFF80000000, 1'b0);
        send_b(32'h0200D093, 3'b110, 8'h31, 64'h0000000000000020, 1'b0);
        send_b(32'hFFF00093, 3'b000, 8'h32, 64'hFFFFFFFFFFFFFFFF, 1'b0);
        send_b(32'hFFFFFFFF, 3'b111, 8'h33, 64'h0000000000000000, 1'b1);
        drain("drain_formats");

        // backpressure: third push must be held until the consumer resumes
        a_out_ready = 1'b0;
        send_a(32'h00100093, 3'b000, 8'h01, 64'h00000001, 1'b0);
        send_a(32'h00200093, 3'b000, 8'h02, 64'h00000002, 1'b0);
        check("full_in_ready", 64'(a_in_ready), 64'd0);
        fork
            send_a(32'h00300093, 3'b000, 8'h03, 64'h00000003, 1'b0);
        join_none
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(a_in_ready), 64'd0);
            check("stall_tag", 64'(a_out_tag), 64'h01);
            check("stall_imm", 64'(a_imm), 64'h00000001);
        end
        @(posedge clk);
        #1 a_out_ready = 1'b1;
        wait fork;
        drain("drain_backpressure");

        // reset while FULL with a pending input that must be ignored
        a_out_ready = 1'b0;
        send_a(32'h02100093, 3'b000, 8'h21, 64'h00000021, 1'b0);
        send_a(32'h02200093, 3'b000, 8'h22, 64'h00000022, 1'b0);
        a_in_valid = 1'b1; a_instr = 32'h07700093; a_src = 3'b000; a_in_tag = 8'h77;
        rst = 1'b1;
        qa.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        a_in_valid = 1'b0;
        check("rst_full_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_full_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_full_imm", 64'(a_imm), 64'd0);
        check("rst_full_tag", 64'(a_out_tag), 64'd0);
        a_out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_idle", 64'(a_out_valid), 64'd0);

        send_a(32'h05500093, 3'b000, 8'h55, 64'h00000055, 1'b0);
        drain("drain_final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
